// File: rtl/magic_device_reader_if.sv
// magic_device_reader_if: MMIO request/response and device read-side bus for magic_device_reader
interface magic_device_reader_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 64
);
    logic              req_valid;
    logic              req_ready;
    logic [ADDR_W-1:0] req_addr;
    logic              resp_valid;
    logic              resp_ready;
    logic [DATA_W-1:0] resp_data;
    logic              resp_error;
    logic [ADDR_W-1:0] read_select;
    logic              read_ready;
    logic              read_valid;
    logic [DATA_W-1:0] read_data;
    modport master (
        input  req_valid, req_addr, resp_ready, read_valid, read_data,
        output req_ready, resp_valid, resp_data, resp_error, read_select, read_ready
    );
    modport slave (
        output req_valid, req_addr, resp_ready, read_valid, read_data,
        input  req_ready, resp_valid, resp_data, resp_error, read_select, read_ready
    );
endinterface

// File: rtl/magic_device_reader.sv
// magic_device_reader: one-outstanding MMIO read to device read transaction with watchdog timeout.
// Optional MAGIC_DEVICE_READER_STATS_EN adds saturating read/timeout counters.
module magic_device_reader #(
    parameter int              ADDR_W   = 12,
    parameter int              DATA_W   = 64,
    parameter int              TIMEOUT  = 1024,
    parameter logic [DATA_W-1:0] ERR_DATA = 64'hDEAD_BEEF_DEAD_BEEF
) (
    input  logic clock,
    input  logic reset,
    magic_device_reader_if.master bus
`ifdef MAGIC_DEVICE_READER_STATS_EN
    ,
    output logic [31:0] stat_reads,
    output logic [15:0] stat_timeouts
`endif
);
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] sel_q, sel_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              timeout_hit;
    assign timeout_hit = TIMEOUT != 0 && cnt_q == CW'(TIMEOUT - 1);
    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        data_d  = data_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: if (bus.req_valid) begin
                sel_d   = bus.req_addr;
                cnt_d   = '0;
                state_d = WAIT;
            end
            WAIT: if (bus.read_valid) begin
                data_d  = bus.read_data;
                err_d   = 1'b0;
                state_d = RESP;
            end else if (timeout_hit) begin
                data_d  = ERR_DATA;
                err_d   = 1'b1;
                state_d = RESP;
            end else begin
                cnt_d = &cnt_q ? cnt_q : cnt_q + 1'b1;
            end
            RESP: state_d = bus.resp_ready ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            sel_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end
    // All outputs decode registered state only, so no input reaches an output combinationally.
    assign bus.req_ready   = state_q == IDLE;
    assign bus.read_ready  = state_q == WAIT;
    assign bus.resp_valid  = state_q == RESP;
    assign bus.resp_data   = data_q;
    assign bus.resp_error  = err_q;
    assign bus.read_select = sel_q;
`ifdef MAGIC_DEVICE_READER_STATS_EN
    logic [31:0] reads_q, reads_d;
    logic [15:0] tos_q, tos_d;
    always_comb begin
        reads_d = reads_q;
        tos_d   = tos_q;
        if (state_q == WAIT && bus.read_valid && !(&reads_q)) reads_d = reads_q + 1'b1;
        if (state_q == WAIT && !bus.read_valid && timeout_hit && !(&tos_q)) tos_d = tos_q + 1'b1;
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            reads_q <= '0;
            tos_q   <= '0;
        end else begin
            reads_q <= reads_d;
            tos_q   <= tos_d;
        end
    end
    assign stat_reads    = reads_q;
    assign stat_timeouts = tos_q;
`endif
endmodule

// File: tb/tb_magic_device_reader.sv
// tb_magic_device_reader: directed and random stimulus checked each cycle against a timestamp-based transaction model.
module tb_magic_device_reader;
    localparam int AW = 12;
    localparam int DW = 64;
    localparam int TO = 8;
    localparam logic [63:0] ERR = 64'hDEAD_BEEF_DEAD_BEEF;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;
    magic_device_reader_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
`ifdef MAGIC_DEVICE_READER_STATS_EN
    logic [31:0] stat_reads;
    logic [15:0] stat_timeouts;
`endif
    magic_device_reader #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO), .ERR_DATA(ERR)) dut (
        .clock(clk),
        .reset(rst),
        .bus(bus.master)
`ifdef MAGIC_DEVICE_READER_STATS_EN
        ,
        .stat_reads(stat_reads),
        .stat_timeouts(stat_timeouts)
`endif
    );
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int t_acc = 0;
    bit busy, have, m_err;
    logic [AW-1:0] m_sel;
    logic [DW-1:0] m_data;
    logic [31:0] m_reads;
    logic [15:0] m_tos;
    task automatic chk(input string n, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", n, cyc, got, exp);
        end
    endtask
    // Transaction model: a read is busy from acceptance until the response handshake;
    // the k-th cycle after acceptance answers with device data, or errors when k reaches TO.
    task automatic model_edge();
        cyc++;
        if (rst) begin
            busy = 0; have = 0; m_err = 0; m_sel = '0; m_data = '0; m_reads = '0; m_tos = '0;
        end else if (!busy) begin
            if (bus.req_valid) begin
                busy = 1; have = 0; m_sel = bus.req_addr; t_acc = cyc;
            end
        end else if (!have) begin
            if (bus.read_valid) begin
                have = 1; m_data = bus.read_data; m_err = 0;
                if (m_reads != 32'hFFFF_FFFF) m_reads = m_reads + 1;
            end else if (TO != 0 && cyc - t_acc == TO) begin
                have = 1; m_data = ERR; m_err = 1;
                if (m_tos != 16'hFFFF) m_tos = m_tos + 1;
            end
        end else if (bus.resp_ready) begin
            busy = 0; have = 0;
        end
    endtask
    task automatic cmp_all();
        chk("req_ready", 64'(bus.req_ready), 64'(!busy));
        chk("read_ready", 64'(bus.read_ready), 64'(busy && !have));
        chk("resp_valid", 64'(bus.resp_valid), 64'(have));
        chk("resp_data", bus.resp_data, m_data);
        chk("resp_error", 64'(bus.resp_error), 64'(m_err));
        chk("read_select", 64'(bus.read_select), 64'(m_sel));
`ifdef MAGIC_DEVICE_READER_STATS_EN
        chk("stat_reads", 64'(stat_reads), 64'(m_reads));
        chk("stat_timeouts", 64'(stat_timeouts), 64'(m_tos));
`endif
    endtask
    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cmp_all();
    endtask
    task automatic req(input logic [AW-1:0] a);
        bus.req_valid = 1; bus.req_addr = a;
        tick();
        bus.req_valid = 0;
    endtask
    task automatic chk_reset_vals(input string n);
        chk({n, "_req_ready"}, 64'(bus.req_ready), 64'd1);
        chk({n, "_read_ready"}, 64'(bus.read_ready), 64'd0);
        chk({n, "_resp_valid"}, 64'(bus.resp_valid), 64'd0);
        chk({n, "_resp_data"}, bus.resp_data, 64'd0);
        chk({n, "_resp_error"}, 64'(bus.resp_error), 64'd0);
        chk({n, "_read_select"}, 64'(bus.read_select), 64'd0);
    endtask
    initial begin
        rst = 1;
        bus.req_valid = 0; bus.req_addr = '0; bus.resp_ready = 1;
        bus.read_valid = 0; bus.read_data = '0;
        @(negedge clk);
        tick(); tick();
        chk_reset_vals("rst");
        rst = 0;
        // basic read, device answers on the first wait cycle
        req(12'h010);
        chk("basic_sel", 64'(bus.read_select), 64'h010);
        chk("basic_read_ready", 64'(bus.read_ready), 64'd1);
        bus.read_valid = 1; bus.read_data = 64'h1122_3344_5566_7788;
        tick();
        bus.read_valid = 0;
        chk("basic_resp_valid", 64'(bus.resp_valid), 64'd1);
        chk("basic_data", bus.resp_data, 64'h1122_3344_5566_7788);
        chk("basic_err", 64'(bus.resp_error), 64'd0);
        chk("basic_read_ready_low", 64'(bus.read_ready), 64'd0);
        tick();
        chk("basic_idle", 64'(bus.req_ready), 64'd1);
        // delayed answer with response backpressure
        bus.resp_ready = 0;
        req(12'h3A5);
        repeat (6) begin
            tick();
            chk("delay_sel", 64'(bus.read_select), 64'h3A5);
            chk("delay_req_ready", 64'(bus.req_ready), 64'd0);
        end
        bus.read_valid = 1; bus.read_data = 64'h0BAD_CAFE_1234_5678;
        tick();
        bus.read_valid = 0;
        repeat (5) begin
            chk("stall_data", bus.resp_data, 64'h0BAD_CAFE_1234_5678);
            chk("stall_valid", 64'(bus.resp_valid), 64'd1);
            chk("stall_req_ready", 64'(bus.req_ready), 64'd0);
            tick();
        end
        chk("stall_last_req_ready", 64'(bus.req_ready), 64'd0);
        bus.resp_ready = 1;
        tick();
        chk("delay_after_hs", 64'(bus.req_ready), 64'd1);
        // timeout, then late device answers in RESP and IDLE
        bus.resp_ready = 0;
        req(12'h7FF);
        repeat (7) tick();
        chk("to_early", 64'(bus.resp_valid), 64'd0);
        tick();
        chk("to_valid", 64'(bus.resp_valid), 64'd1);
        chk("to_data", bus.resp_data, 64'hDEAD_BEEF_DEAD_BEEF);
        chk("to_err", 64'(bus.resp_error), 64'd1);
        bus.read_valid = 1; bus.read_data = 64'h5555_6666_7777_8888;
        tick();
        bus.read_valid = 0;
        chk("to_late_data", bus.resp_data, 64'hDEAD_BEEF_DEAD_BEEF);
        chk("to_late_err", 64'(bus.resp_error), 64'd1);
        bus.resp_ready = 1;
        tick();
        bus.read_valid = 1;
        tick();
        bus.read_valid = 0;
        chk("idle_stale_valid", 64'(bus.resp_valid), 64'd0);
        chk("idle_stale_rdy", 64'(bus.req_ready), 64'd1);
        chk("idle_stale_data", bus.resp_data, 64'hDEAD_BEEF_DEAD_BEEF);
        // answer on the final wait cycle wins over the timeout
        req(12'h0AB);
        repeat (7) tick();
        bus.read_valid = 1; bus.read_data = 64'hCAFE_F00D_0000_0001;
        tick();
        bus.read_valid = 0;
        chk("tie_valid", 64'(bus.resp_valid), 64'd1);
        chk("tie_data", bus.resp_data, 64'hCAFE_F00D_0000_0001);
        chk("tie_err", 64'(bus.resp_error), 64'd0);
        tick();
        // reset three cycles into a wait
        req(12'h555);
        repeat (3) tick();
`ifdef MAGIC_DEVICE_READER_STATS_EN
        chk("stat_reads_lit", 64'(stat_reads), 64'd3);
        chk("stat_to_lit", 64'(stat_timeouts), 64'd1);
`endif
        rst = 1;
        tick();
        rst = 0;
        chk_reset_vals("midrst");
`ifdef MAGIC_DEVICE_READER_STATS_EN
        chk("stat_reads_rst", 64'(stat_reads), 64'd0);
        chk("stat_to_rst", 64'(stat_timeouts), 64'd0);
`endif
        bus.read_valid = 1; bus.read_data = 64'hFFFF_0000_FFFF_0000;
        tick();
        bus.read_valid = 0;
        chk("midrst_no_resp", 64'(bus.resp_valid), 64'd0);
        req(12'h123);
        bus.read_valid = 1; bus.read_data = 64'h0123_4567_89AB_CDEF;
        tick();
        bus.read_valid = 0;
        chk("post_rst_valid", 64'(bus.resp_valid), 64'd1);
        chk("post_rst_data", bus.resp_data, 64'h0123_4567_89AB_CDEF);
        tick();
        // randomized traffic; rare device answers make timeouts frequent
        repeat (3000) begin
            rst = $urandom_range(0, 299) == 0;
            bus.req_valid = $urandom_range(0, 2) != 0;
            bus.req_addr = AW'($urandom);
            bus.resp_ready = $urandom_range(0, 2) != 0;
            bus.read_valid = $urandom_range(0, 6) == 0;
            bus.read_data = {$urandom, $urandom};
            tick();
        end
        rst = 0; bus.req_valid = 0; bus.read_valid = 0; bus.resp_ready = 1;
        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
